// File: rtl/delay_timer_scheduler_pkg.sv
// Shared definitions for the delay timer scheduler: timer register map,
// control word and scheduler state encoding.
package dts_pkg;

    localparam logic [2:0]  TMR_STATUS  = 3'd0;
    localparam logic [2:0]  TMR_CONTROL = 3'd1;
    localparam logic [2:0]  TMR_PERIODL = 3'd2;
    localparam logic [2:0]  TMR_PERIODH = 3'd3;

    localparam logic [15:0] CTRL_ITO    = 16'h0001;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR_PL,
        WR_PH,
        CLR_ST,
        WAIT,
        CLR,
        ZERO
    } dts_state_t;

endpackage

// File: rtl/delay_timer_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after rr_ptr, wrapping.
// The pointer itself is owned and updated by the parent.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [2:0]      rr_ptr,
    output logic [2:0]      gnt_idx,
    output logic            valid
);

    logic [7:0] req_pad;

    assign req_pad = 8'(req);

    always_comb begin
        int unsigned slot;
        valid   = 1'b0;
        gnt_idx = '0;
        slot    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            slot = 32'(rr_ptr) + k;
            if (slot >= NREQ) begin
                slot = slot - NREQ;
            end
            if (!valid && req_pad[slot[2:0]]) begin
                valid   = 1'b1;
                gnt_idx = slot[2:0];
            end
        end
    end

endmodule

// File: rtl/delay_timer_scheduler.sv
// Shares one interval timer among NREQ requesters: round-robin grant,
// programs the period, waits for the irq and pulses done to the owner.
module delay_timer_scheduler
    import dts_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] delay,
    output logic [NREQ-1:0]  done,
    output logic             busy,
    output logic [2:0]       grant_id,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic             tmr_irq
);

    dts_state_t      state, next_state;
    logic [2:0]      rr_ptr, rr_ptr_d;
    logic [DW-1:0]   d_q, d_d, d_m1;
    logic [2:0]      grant_d;
    logic [NREQ-1:0] done_d;
    logic            busy_d;
    logic [2:0]      addr_d;
    logic            cs_d;
    logic            wn_d;
    logic [15:0]     wdata_d;
    logic            abort;

    logic [2:0]      arb_idx;
    logic            arb_valid;
    logic [DW-1:0]   delay_sel;
    logic [7:0]      req_pad;

    assign req_pad = 8'(req);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt_idx (arb_idx),
        .valid   (arb_valid)
    );

    always_comb begin
        delay_sel = '0;
        for (int unsigned b = 0; b < NREQ; b++) begin
            if (3'(b) == arb_idx) begin
                delay_sel = delay[b*DW +: DW];
            end
        end
    end

    // Next state and latched grant data
    always_comb begin
        next_state = state;
        rr_ptr_d   = rr_ptr;
        grant_d    = grant_id;
        d_d        = d_q;
        abort      = 1'b0;
        case (state)
            INIT: begin
                if (tmr_chipselect) begin
                    next_state = IDLE;
                end
            end
            IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_idx;
                    rr_ptr_d = arb_idx;
                    d_d      = delay_sel;
                    next_state = (delay_sel == '0) ? ZERO : WR_PL;
                end
            end
            WR_PL:  next_state = WR_PH;
            WR_PH:  next_state = CLR_ST;
            CLR_ST: next_state = WAIT;
            WAIT: begin
                if (!req_pad[grant_id]) begin
                    next_state = CLR;
                    abort      = 1'b1;
                end else if (tmr_irq) begin
                    next_state = CLR;
                end
            end
            CLR:     next_state = IDLE;
            ZERO:    next_state = IDLE;
            default: next_state = INIT;
        endcase
    end

    assign d_m1 = d_d - DW'(1);

    // Registered outputs are decoded from the state being entered, so each
    // bus cycle appears on the pins while that state is current.
    always_comb begin
        cs_d    = 1'b0;
        wn_d    = 1'b1;
        addr_d  = '0;
        wdata_d = '0;
        done_d  = '0;
        busy_d  = (next_state != INIT) && (next_state != IDLE);
        case (next_state)
            INIT: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = TMR_CONTROL;
                wdata_d = CTRL_ITO;
            end
            WR_PL: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = TMR_PERIODL;
                wdata_d = d_m1[15:0];
            end
            WR_PH: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = TMR_PERIODH;
                wdata_d = d_m1[DW-1:16];
            end
            CLR_ST: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = TMR_STATUS;
            end
            CLR: begin
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = TMR_STATUS;
                if (!abort) begin
                    done_d = {{(NREQ-1){1'b0}}, 1'b1} << grant_d;
                end
            end
            ZERO: begin
                done_d = {{(NREQ-1){1'b0}}, 1'b1} << grant_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= INIT;
            rr_ptr         <= 3'(NREQ - 1);
            d_q            <= '0;
            grant_id       <= '0;
            done           <= '0;
            busy           <= 1'b0;
            tmr_address    <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
        end else begin
            state          <= next_state;
            rr_ptr         <= rr_ptr_d;
            d_q            <= d_d;
            grant_id       <= grant_d;
            done           <= done_d;
            busy           <= busy_d;
            tmr_address    <= addr_d;
            tmr_chipselect <= cs_d;
            tmr_write_n    <= wn_d;
            tmr_writedata  <= wdata_d;
        end
    end

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// Directed bench for delay_timer_scheduler with a small interval-timer model
// answering the bus; checks use immediate assertions.
module tb_delay_timer_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] delay = '0;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [2:0]        grant_id;
    logic [2:0]        tmr_address;
    logic              tmr_chipselect;
    logic              tmr_write_n;
    logic [15:0]       tmr_writedata;
    logic              tmr_irq;

    always #5 clk = ~clk;

    delay_timer_scheduler #(
        .NREQ (NREQ),
        .DW   (DW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .delay          (delay),
        .done           (done),
        .busy           (busy),
        .grant_id       (grant_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    // Timer model: status write clears timeout and restarts the countdown
    logic [31:0] t_period, t_cnt;
    logic        t_to, t_ito, t_run;

    assign tmr_irq = t_to & t_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_period <= '0;
            t_cnt    <= '0;
            t_to     <= 1'b0;
            t_ito    <= 1'b0;
            t_run    <= 1'b0;
        end else if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: begin t_to <= 1'b0; t_cnt <= t_period; t_run <= 1'b1; end
                3'd1: t_ito <= tmr_writedata[0];
                3'd2: t_period[15:0]  <= tmr_writedata;
                3'd3: t_period[31:16] <= tmr_writedata;
                default: ;
            endcase
        end else if (t_run) begin
            if (t_cnt == 0) begin
                t_to  <= 1'b1;
                t_cnt <= t_period;
            end else begin
                t_cnt <= t_cnt - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nw = 0;
    logic [2:0]  wr_addr [16];
    logic [15:0] wr_data [16];
    int ndone = 0;
    logic [NREQ-1:0] last_done = '0;
    int last_done_cyc = 0;
    int busy_rise = 0;
    logic busy_q = 1'b0;
    int bad_onehot = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tmr_chipselect && !tmr_write_n) begin
            if (nw < 16) begin
                wr_addr[nw] = tmr_address;
                wr_data[nw] = tmr_writedata;
            end
            nw++;
        end
        if (done != '0) begin
            last_done     = done;
            last_done_cyc = cyc;
            ndone++;
            if ((done & (done - 1'b1)) != '0) bad_onehot++;
        end
        if (busy && !busy_q) busy_rise = cyc;
        busy_q = busy;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            tick();
            if (done != '0) got = 1'b1;
        end
        check({tag, "_timeout"}, 32'(got), 32'd1);
    endtask

    int prev_done_cyc;
    int snap;

    initial begin
        // 1: reset values, then the single control write from INIT
        repeat (3) tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_cs", 32'(tmr_chipselect), 32'd0);
        check("rst_wn", 32'(tmr_write_n), 32'd1);
        check("rst_addr", 32'(tmr_address), 32'd0);
        check("rst_wdata", 32'(tmr_writedata), 32'd0);
        nw = 0;
        reset_n = 1'b1;
        repeat (6) tick();
        check("init_nw", 32'(nw), 32'd1);
        check("init_addr", 32'(wr_addr[0]), 32'd1);
        check("init_data", 32'(wr_data[0]), 32'h0001);
        check("init_busy", 32'(busy), 32'd0);

        // 3: all four requesters at once, rr_ptr fresh from reset
        for (int k = 0; k < NREQ; k++) delay[k*DW +: DW] = 32'd100;
        req = 4'hF;
        snap = ndone;
        prev_done_cyc = 0;
        for (int k = 0; k < NREQ; k++) begin
            wait_done(300, "rr");
            check($sformatf("rr_order%0d", k), 32'(last_done), 32'(1 << k));
            check($sformatf("rr_grant%0d", k), 32'(grant_id), 32'(k));
            check($sformatf("rr_lat%0d", k), 32'(last_done_cyc - busy_rise), 32'd104);
            if (k > 0) check($sformatf("rr_gap%0d", k), 32'(busy_rise - prev_done_cyc), 32'd2);
            prev_done_cyc = last_done_cyc;
            req[k] = 1'b0;
        end
        repeat (3) tick();
        check("rr_count", 32'(ndone - snap), 32'd4);
        check("rr_idle", 32'(busy), 32'd0);

        // 2: single request, delay 10
        delay[0*DW +: DW] = 32'd10;
        nw = 0;
        req[0] = 1'b1;
        wait_done(50, "d10");
        req[0] = 1'b0;
        check("d10_who", 32'(last_done), 32'h1);
        check("d10_lat", 32'(last_done_cyc - busy_rise), 32'd14);
        check("d10_nw", 32'(nw), 32'd4);
        check("d10_a0", 32'(wr_addr[0]), 32'd2);
        check("d10_v0", 32'(wr_data[0]), 32'h0009);
        check("d10_a1", 32'(wr_addr[1]), 32'd3);
        check("d10_v1", 32'(wr_data[1]), 32'h0000);
        check("d10_a2", 32'(wr_addr[2]), 32'd0);
        check("d10_a3", 32'(wr_addr[3]), 32'd0);
        tick();
        check("d10_status_clear", 32'(t_to), 32'd0);

        // 4: long delay split across both period halves, then zero delay
        delay[2*DW +: DW] = 32'h0001_2345;
        nw = 0;
        req[2] = 1'b1;
        wait_done(80000, "long");
        req[2] = 1'b0;
        check("long_who", 32'(last_done), 32'h4);
        check("long_lat", 32'(last_done_cyc - busy_rise), 32'h0001_2349);
        check("long_pl", 32'(wr_data[0]), 32'h2344);
        check("long_ph", 32'(wr_data[1]), 32'h0001);
        repeat (2) tick();
        delay[1*DW +: DW] = 32'd0;
        nw = 0;
        req[1] = 1'b1;
        wait_done(10, "zero");
        req[1] = 1'b0;
        check("zero_who", 32'(last_done), 32'h2);
        check("zero_lat", 32'(last_done_cyc - busy_rise), 32'd0);
        repeat (2) tick();
        check("zero_nw", 32'(nw), 32'd0);

        // 5: abort by dropping req during WAIT, then a normal request
        delay[1*DW +: DW] = 32'd1000;
        req[1] = 1'b1;
        repeat (200) tick();
        nw = 0;
        snap = ndone;
        req[1] = 1'b0;
        repeat (10) tick();
        check("abort_nw", 32'(nw), 32'd1);
        check("abort_addr", 32'(wr_addr[0]), 32'd0);
        check("abort_nodone", 32'(ndone - snap), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        delay[3*DW +: DW] = 32'd5;
        req[3] = 1'b1;
        wait_done(50, "after_abort");
        req[3] = 1'b0;
        check("after_abort_who", 32'(last_done), 32'h8);
        check("after_abort_lat", 32'(last_done_cyc - busy_rise), 32'd9);
        repeat (2) tick();

        // 6: reset in WAIT of a 500-cycle delay
        delay[0*DW +: DW] = 32'd500;
        req[0] = 1'b1;
        repeat (100) tick();
        check("mid_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cs", 32'(tmr_chipselect), 32'd0);
        check("mid_rst_wn", 32'(tmr_write_n), 32'd1);
        check("mid_rst_grant", 32'(grant_id), 32'd0);
        req[0] = 1'b0;
        repeat (3) tick();
        nw = 0;
        snap = ndone;
        reset_n = 1'b1;
        repeat (10) tick();
        check("mid_init_nw", 32'(nw), 32'd1);
        check("mid_init_addr", 32'(wr_addr[0]), 32'd1);
        check("mid_init_data", 32'(wr_data[0]), 32'h0001);
        check("mid_nodone", 32'(ndone - snap), 32'd0);

        check("done_onehot", 32'(bad_onehot), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
